// File: rtl/ftdi_cmd_decoder_pkg.sv
// Shared constants, state encodings and helpers for the FTDI command decoder.
package ftdi_cmd_decoder_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] RSP_OK    = 8'h5A;
    localparam logic [7:0] RSP_ERR   = 8'hEE;
    localparam logic [7:0] CMD_WR    = 8'h01;
    localparam logic [7:0] CMD_RD    = 8'h02;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CMD    = 3'd1,
        S_ADDR   = 3'd2,
        S_DATA   = 3'd3,
        S_EXEC   = 3'd4,
        S_RDWAIT = 3'd5,
        S_TX     = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        H_IDLE = 2'd0,
        H_REQ  = 2'd1,
        H_WAIT = 2'd2
    } hsk_state_t;

    // Saturating increment for the error counter; never wraps past 0xFF.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ftdi_hsk_tx.sv
// One-byte TX 4-phase req/ack driver; completes on the FTDI write falling edge.
module ftdi_hsk_tx
    import ftdi_cmd_decoder_pkg::*;
(
    input  logic       in_clk,
    input  logic       in_rst,
    input  logic       in_start,
    input  logic [7:0] in_byte,
    output logic [7:0] out_tx_data,
    output logic       out_tx_hsk_req,
    input  logic       in_tx_hsk_ack,
    input  logic       in_ftdi_wr_mon,
    output logic       out_done
);

    hsk_state_t state_q;
    logic       wr_mon_q;
    logic       fall_seen_q;
    logic       wr_fall;

    assign wr_fall = wr_mon_q && !in_ftdi_wr_mon;

    // Byte/req launch, ack wait, then wait for write completion (fall remembered if early).
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q        <= H_IDLE;
            wr_mon_q       <= 1'b0;
            fall_seen_q    <= 1'b0;
            out_tx_data    <= 8'h00;
            out_tx_hsk_req <= 1'b0;
            out_done       <= 1'b0;
        end else begin
            wr_mon_q <= in_ftdi_wr_mon;
            out_done <= 1'b0;
            case (state_q)
                H_IDLE: begin
                    if (in_start) begin
                        out_tx_data    <= in_byte;
                        out_tx_hsk_req <= 1'b1;
                        fall_seen_q    <= 1'b0;
                        state_q        <= H_REQ;
                    end
                end
                H_REQ: begin
                    if (wr_fall) fall_seen_q <= 1'b1;
                    if (in_tx_hsk_ack) begin
                        out_tx_hsk_req <= 1'b0;
                        state_q        <= H_WAIT;
                    end
                end
                H_WAIT: begin
                    if (wr_fall) fall_seen_q <= 1'b1;
                    if ((wr_fall || fall_seen_q) && !in_tx_hsk_ack) begin
                        out_done <= 1'b1;
                        state_q  <= H_IDLE;
                    end
                end
                default: state_q <= H_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ftdi_cmd_decoder.sv
// Parses A5/CMD/ADDR[/DATA] frames from the FTDI RX handshake, runs local register
// accesses and returns the response bytes over the TX handshake.
module ftdi_cmd_decoder
    import ftdi_cmd_decoder_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned TIMEOUT_W  = 16,
    parameter int unsigned RX_TIMEOUT = 50000
) (
    input  logic       in_clk,
    input  logic       in_rst,
    output logic       out_rx_en,
    input  logic [7:0] in_rx_data,
    input  logic       in_rx_hsk_req,
    output logic       out_rx_hsk_ack,
    output logic [7:0] out_tx_data,
    output logic       out_tx_hsk_req,
    input  logic       in_tx_hsk_ack,
    input  logic       in_ftdi_wr_mon,
    output logic [7:0] out_reg_addr,
    output logic [7:0] out_reg_wdata,
    output logic       out_reg_we,
    output logic       out_reg_re,
    input  logic [7:0] in_reg_rdata,
    output logic [7:0] out_err_count
);

    state_t               state_q;
    logic [7:0]           rsp_q [0:2];
    logic [1:0]           rsp_len_q;
    logic [1:0]           idx_q;
    logic                 is_wr_q;
    logic [TIMEOUT_W-1:0] tmo_q;
    logic [2:0]           rdcnt_q;
    logic                 tx_start_q;
    logic                 tx_done;
    logic [7:0]           tx_byte;
    logic                 rx_state;
    logic                 frame_state;
    logic                 rx_take;
    logic                 tmo_hit;

    assign frame_state = (state_q == S_CMD) || (state_q == S_ADDR) || (state_q == S_DATA);
    assign rx_state    = (state_q == S_IDLE) || frame_state;
    assign rx_take     = in_rx_hsk_req && !out_rx_hsk_ack && rx_state;
    assign tmo_hit     = (RX_TIMEOUT != 0) && frame_state &&
                         (tmo_q == TIMEOUT_W'(RX_TIMEOUT - 1));
    assign tx_byte     = (idx_q == 2'd2) ? rsp_q[2] :
                         (idx_q == 2'd1) ? rsp_q[1] : rsp_q[0];

    // Frame parser, register access sequencing and response indexing.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q        <= S_IDLE;
            rsp_q[0]       <= 8'h00;
            rsp_q[1]       <= 8'h00;
            rsp_q[2]       <= 8'h00;
            rsp_len_q      <= 2'd0;
            idx_q          <= 2'd0;
            is_wr_q        <= 1'b0;
            tmo_q          <= '0;
            rdcnt_q        <= 3'd0;
            tx_start_q     <= 1'b0;
            out_rx_en      <= 1'b0;
            out_rx_hsk_ack <= 1'b0;
            out_reg_addr   <= 8'h00;
            out_reg_wdata  <= 8'h00;
            out_reg_we     <= 1'b0;
            out_reg_re     <= 1'b0;
            out_err_count  <= 8'h00;
        end else begin
            out_reg_we <= 1'b0;
            out_reg_re <= 1'b0;
            tx_start_q <= 1'b0;

            if (rx_take)
                out_rx_hsk_ack <= 1'b1;
            else if (out_rx_hsk_ack && !in_rx_hsk_req)
                out_rx_hsk_ack <= 1'b0;

            if (rx_take || !frame_state)
                tmo_q <= '0;
            else
                tmo_q <= tmo_q + TIMEOUT_W'(1);

            case (state_q)
                S_IDLE: begin
                    out_rx_en <= 1'b1;
                    if (rx_take) begin
                        if (in_rx_data == SYNC_BYTE) state_q <= S_CMD;
                        else out_err_count <= sat_inc(out_err_count);
                    end
                end
                S_CMD: begin
                    if (rx_take) begin
                        if (in_rx_data == CMD_WR || in_rx_data == CMD_RD) begin
                            is_wr_q <= (in_rx_data == CMD_WR);
                            state_q <= S_ADDR;
                        end else begin
                            rsp_q[0]      <= RSP_ERR;
                            rsp_q[1]      <= in_rx_data;
                            rsp_len_q     <= 2'd2;
                            idx_q         <= 2'd0;
                            tx_start_q    <= 1'b1;
                            out_rx_en     <= 1'b0;
                            out_err_count <= sat_inc(out_err_count);
                            state_q       <= S_TX;
                        end
                    end else if (tmo_hit) begin
                        out_err_count <= sat_inc(out_err_count);
                        state_q       <= S_IDLE;
                    end
                end
                S_ADDR: begin
                    if (rx_take) begin
                        out_reg_addr <= in_rx_data;
                        rsp_q[0]     <= RSP_OK;
                        rsp_q[1]     <= in_rx_data;
                        if (is_wr_q) begin
                            state_q <= S_DATA;
                        end else begin
                            out_rx_en <= 1'b0;
                            state_q   <= S_EXEC;
                        end
                    end else if (tmo_hit) begin
                        out_err_count <= sat_inc(out_err_count);
                        state_q       <= S_IDLE;
                    end
                end
                S_DATA: begin
                    if (rx_take) begin
                        out_reg_wdata <= in_rx_data;
                        out_rx_en     <= 1'b0;
                        state_q       <= S_EXEC;
                    end else if (tmo_hit) begin
                        out_err_count <= sat_inc(out_err_count);
                        state_q       <= S_IDLE;
                    end
                end
                S_EXEC: begin
                    idx_q <= 2'd0;
                    if (is_wr_q) begin
                        out_reg_we <= 1'b1;
                        rsp_len_q  <= 2'd2;
                        tx_start_q <= 1'b1;
                        state_q    <= S_TX;
                    end else begin
                        out_reg_re <= 1'b1;
                        rdcnt_q    <= 3'd0;
                        state_q    <= S_RDWAIT;
                    end
                end
                S_RDWAIT: begin
                    if (rdcnt_q == 3'(RD_LATENCY)) begin
                        rsp_q[2]   <= in_reg_rdata;
                        rsp_len_q  <= 2'd3;
                        tx_start_q <= 1'b1;
                        state_q    <= S_TX;
                    end else begin
                        rdcnt_q <= rdcnt_q + 3'd1;
                    end
                end
                S_TX: begin
                    if (tx_done) begin
                        if (idx_q == rsp_len_q - 2'd1) begin
                            out_rx_en <= 1'b1;
                            state_q   <= S_IDLE;
                        end else begin
                            idx_q      <= idx_q + 2'd1;
                            tx_start_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    ftdi_hsk_tx u_hsk_tx (
        .in_clk         (in_clk),
        .in_rst         (in_rst),
        .in_start       (tx_start_q),
        .in_byte        (tx_byte),
        .out_tx_data    (out_tx_data),
        .out_tx_hsk_req (out_tx_hsk_req),
        .in_tx_hsk_ack  (in_tx_hsk_ack),
        .in_ftdi_wr_mon (in_ftdi_wr_mon),
        .out_done       (tx_done)
    );

endmodule

// File: tb/tb_ftdi_cmd_decoder.sv
// Directed bench for ftdi_cmd_decoder with a small FTDI controller / register file model.
module tb_ftdi_cmd_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_en;
    logic [7:0] rx_data;
    logic       rx_req;
    logic       rx_ack;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       tx_ack;
    logic       wr_mon;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic [7:0] err_count;

    int errors = 0;
    int checks = 0;

    // Controller TX-side model state
    logic [7:0] tx_log [$];
    int         wr_delay = 3;
    int         tx_unstable = 0;
    logic [7:0] tx_cap;

    // Register file model: rdata valid only exactly 3 cycles after re
    logic [7:0] rd_val = 8'h00;
    logic [2:0] re_pipe = 3'b000;
    int         we_cnt = 0;
    int         re_cnt = 0;
    int         overlap = 0;
    logic [7:0] we_addr = 8'h00;
    logic [7:0] we_data = 8'h00;
    logic [7:0] re_addr = 8'h00;

    assign reg_rdata = re_pipe[2] ? rd_val : 8'h00;

    always #5 clk = ~clk;

    ftdi_cmd_decoder #(
        .RD_LATENCY (3),
        .TIMEOUT_W  (16),
        .RX_TIMEOUT (100)
    ) dut (
        .in_clk         (clk),
        .in_rst         (rst),
        .out_rx_en      (rx_en),
        .in_rx_data     (rx_data),
        .in_rx_hsk_req  (rx_req),
        .out_rx_hsk_ack (rx_ack),
        .out_tx_data    (tx_data),
        .out_tx_hsk_req (tx_req),
        .in_tx_hsk_ack  (tx_ack),
        .in_ftdi_wr_mon (wr_mon),
        .out_reg_addr   (reg_addr),
        .out_reg_wdata  (reg_wdata),
        .out_reg_we     (reg_we),
        .out_reg_re     (reg_re),
        .in_reg_rdata   (reg_rdata),
        .out_err_count  (err_count)
    );

    always @(posedge clk) re_pipe <= {re_pipe[1:0], reg_re};

    // Strobe monitor
    always @(negedge clk) begin
        if (reg_we) begin
            we_cnt  <= we_cnt + 1;
            we_addr <= reg_addr;
            we_data <= reg_wdata;
        end
        if (reg_re) begin
            re_cnt  <= re_cnt + 1;
            re_addr <= reg_addr;
        end
        if (reg_we && reg_re) overlap <= overlap + 1;
    end

    // Controller TX responder: ack on req, release, then an FTDI write pulse of wr_delay cycles
    initial begin
        tx_ack = 1'b0;
        wr_mon = 1'b0;
        tx_cap = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                tx_ack = 1'b0;
                wr_mon = 1'b0;
            end else if (tx_req && !tx_ack) begin
                tx_ack = 1'b1;
                tx_cap = tx_data;
                tx_log.push_back(tx_data);
            end else if (!tx_req && tx_ack) begin
                tx_ack = 1'b0;
                wr_mon = 1'b1;
                for (int i = 0; i < wr_delay; i++) begin
                    @(posedge clk);
                    #1;
                    if (!rst && tx_data !== tx_cap) tx_unstable++;
                end
                wr_mon = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input string tag);
        int n;
        n = 0;
        while (rx_ack && n < 3000) begin tick(1); n++; end
        rx_data = b;
        rx_req  = 1'b1;
        n = 0;
        while (!rx_ack && n < 3000) begin tick(1); n++; end
        chk({tag, " ack"}, 32'(rx_ack), 32'd1);
        rx_req = 1'b0;
        n = 0;
        while (rx_ack && n < 3000) begin tick(1); n++; end
    endtask

    task automatic wait_tx(input int nbytes);
        int n;
        n = 0;
        while (!(tx_log.size() >= nbytes && rx_en && !wr_mon && !tx_req) && n < 3000) begin
            tick(1);
            n++;
        end
        tick(5);
    endtask

    task automatic wait_tx_req();
        int n;
        n = 0;
        while (!tx_req && n < 3000) begin tick(1); n++; end
    endtask

    initial begin
        int we0;
        int re0;
        int err0;
        rst     = 1'b1;
        rx_data = 8'h00;
        rx_req  = 1'b0;
        tick(3);

        // Reset state
        chk("rst rx_en",   32'(rx_en), 32'd0);
        chk("rst rx_ack",  32'(rx_ack), 32'd0);
        chk("rst tx_req",  32'(tx_req), 32'd0);
        chk("rst tx_data", 32'(tx_data), 32'h00);
        chk("rst we/re",   32'({reg_we, reg_re}), 32'd0);
        chk("rst addr",    32'(reg_addr), 32'h00);
        chk("rst err",     32'(err_count), 32'h00);
        rst = 1'b0;
        chk("rx_en still low at release", 32'(rx_en), 32'd0);
        tick(1);
        chk("rx_en after first clock", 32'(rx_en), 32'd1);

        // 1: write 0x3C to 0x10
        tx_log.delete();
        send_byte(8'hA5, "t1 sync");
        send_byte(8'h01, "t1 cmd");
        send_byte(8'h10, "t1 addr");
        send_byte(8'h3C, "t1 data");
        wait_tx_req();
        chk("t1 rx_en low in tx", 32'(rx_en), 32'd0);
        wait_tx(2);
        chk("t1 we count", 32'(we_cnt), 32'd1);
        chk("t1 we addr",  32'(we_addr), 32'h10);
        chk("t1 we data",  32'(we_data), 32'h3C);
        chk("t1 re count", 32'(re_cnt), 32'd0);
        chk("t1 tx len",   32'(tx_log.size()), 32'd2);
        if (tx_log.size() >= 2) begin
            chk("t1 tx0", 32'(tx_log[0]), 32'h5A);
            chk("t1 tx1", 32'(tx_log[1]), 32'h10);
        end
        chk("t1 err", 32'(err_count), 32'h00);

        // 2: read 0x22, rdata 0x99 valid exactly 3 cycles after re
        tx_log.delete();
        rd_val = 8'h99;
        send_byte(8'hA5, "t2 sync");
        send_byte(8'h02, "t2 cmd");
        send_byte(8'h22, "t2 addr");
        wait_tx(3);
        chk("t2 re count", 32'(re_cnt), 32'd1);
        chk("t2 re addr",  32'(re_addr), 32'h22);
        chk("t2 we count", 32'(we_cnt), 32'd1);
        chk("t2 tx len",   32'(tx_log.size()), 32'd3);
        if (tx_log.size() >= 3) begin
            chk("t2 tx0", 32'(tx_log[0]), 32'h5A);
            chk("t2 tx1", 32'(tx_log[1]), 32'h22);
            chk("t2 tx2 rdata", 32'(tx_log[2]), 32'h99);
        end

        // 3: bad syncs and bad command
        tx_log.delete();
        we0 = we_cnt;
        re0 = re_cnt;
        send_byte(8'h00, "t3 b0");
        send_byte(8'hFF, "t3 b1");
        send_byte(8'hA5, "t3 sync");
        send_byte(8'h07, "t3 cmd");
        wait_tx(2);
        chk("t3 err", 32'(err_count), 32'd3);
        chk("t3 no strobes", 32'((we_cnt - we0) + (re_cnt - re0)), 32'd0);
        if (tx_log.size() >= 2) begin
            chk("t3 tx0", 32'(tx_log[0]), 32'hEE);
            chk("t3 tx1", 32'(tx_log[1]), 32'h07);
        end else begin
            chk("t3 tx len", 32'(tx_log.size()), 32'd2);
        end

        // 4: timeout after A5 01, then a good read
        tx_log.delete();
        send_byte(8'hA5, "t4 sync");
        send_byte(8'h01, "t4 cmd");
        tick(90);
        chk("t4 no abort yet", 32'(err_count), 32'd3);
        tick(15);
        chk("t4 abort err", 32'(err_count), 32'd4);
        rd_val = 8'h77;
        send_byte(8'hA5, "t4 sync2");
        send_byte(8'h02, "t4 cmd2");
        send_byte(8'h05, "t4 addr2");
        wait_tx(3);
        chk("t4 tx len", 32'(tx_log.size()), 32'd3);
        if (tx_log.size() >= 3) begin
            chk("t4 tx1", 32'(tx_log[1]), 32'h05);
            chk("t4 tx2", 32'(tx_log[2]), 32'h77);
        end
        chk("t4 re addr", 32'(re_addr), 32'h05);

        // 5: RX req during TX with a slow FTDI write
        tx_log.delete();
        wr_delay = 40;
        rd_val   = 8'h5C;
        send_byte(8'hA5, "t5 sync");
        send_byte(8'h02, "t5 cmd");
        send_byte(8'h33, "t5 addr");
        wait_tx_req();
        rx_data = 8'hA5;
        rx_req  = 1'b1;
        tick(20);
        chk("t5 ack withheld", 32'(rx_ack), 32'd0);
        chk("t5 rx_en low", 32'(rx_en), 32'd0);
        begin
            int n;
            n = 0;
            while (!rx_ack && n < 3000) begin tick(1); n++; end
        end
        chk("t5 deferred ack", 32'(rx_ack), 32'd1);
        chk("t5 tx done first", 32'(tx_log.size()), 32'd3);
        chk("t5 wr low at ack", 32'(wr_mon), 32'd0);
        rx_req = 1'b0;
        wr_delay = 3;
        tick(3);
        if (tx_log.size() >= 3) chk("t5 tx2", 32'(tx_log[2]), 32'h5C);
        tx_log.delete();
        send_byte(8'h01, "t5 cmd2");
        send_byte(8'h30, "t5 addr2");
        send_byte(8'h44, "t5 data2");
        wait_tx(2);
        chk("t5 we addr", 32'(we_addr), 32'h30);
        chk("t5 we data", 32'(we_data), 32'h44);
        chk("t5 tx stable", 32'(tx_unstable), 32'd0);
        chk("t5 err", 32'(err_count), 32'd4);

        // 6: async reset during the write response
        tx_log.delete();
        send_byte(8'hA5, "t6 sync");
        send_byte(8'h01, "t6 cmd");
        send_byte(8'h40, "t6 addr");
        send_byte(8'h5F, "t6 data");
        begin
            int n;
            n = 0;
            while (!tx_ack && n < 3000) begin tick(1); n++; end
        end
        rst = 1'b1;
        #1;
        chk("t6 async tx_data", 32'(tx_data), 32'h00);
        chk("t6 async addr/wdata", 32'({reg_addr, reg_wdata}), 32'h0000);
        chk("t6 async err", 32'(err_count), 32'h00);
        chk("t6 async rx_en/ack", 32'({rx_en, rx_ack}), 32'd0);
        tick(3);
        rst = 1'b0;
        tick(6);
        tx_log.delete();
        err0 = 0;
        rd_val = 8'h3E;
        send_byte(8'hA5, "t6 sync2");
        send_byte(8'h02, "t6 cmd2");
        send_byte(8'h61, "t6 addr2");
        wait_tx(3);
        chk("t6 tx len", 32'(tx_log.size()), 32'd3);
        if (tx_log.size() >= 3) begin
            chk("t6 tx0", 32'(tx_log[0]), 32'h5A);
            chk("t6 tx1", 32'(tx_log[1]), 32'h61);
            chk("t6 tx2", 32'(tx_log[2]), 32'h3E);
        end
        chk("t6 err", 32'(err_count), 32'(err0));
        chk("strobe overlap", 32'(overlap), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
